// File: rtl/register_file_sb.sv
// Register file with one lane-masked write port, two read ports (combinational or registered),
// same-cycle write-to-read forwarding and a per-register pending scoreboard for issue control.
module register_file_sb #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int READ_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        wr_ppp,
  input  logic [ADDR_W-1:0] rA_addr,
  input  logic [ADDR_W-1:0] rB_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rA_data,
  output logic [DATA_W-1:0] rB_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rA_busy,
  output logic              rB_busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [2:0] {
    PPP_WORD  = 3'b000,
    PPP_UPPER = 3'b001,
    PPP_LOWER = 3'b010,
    PPP_EVEN  = 3'b011,
    PPP_ODD   = 3'b100
  } ppp_e;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] a_comb, b_comb;
  logic              hit_a, hit_b;

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_word,
                                               input logic [DATA_W-1:0] new_word,
                                               input logic [DATA_W-1:0] mask);
    return (old_word & ~mask) | (new_word & mask);
  endfunction

  // Word bit 0 (the architectural MSB) is vector bit DATA_W-1, so byte k sits at [DATA_W-1-8k -: 8].
  always_comb begin
    // NOTE: default first so every path assigns the mask and no latch is inferred.
    lane_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      case (wr_ppp)
        PPP_WORD:  lane_mask[i] = 1'b1;
        PPP_UPPER: lane_mask[i] = (i >= DATA_W/2);
        PPP_LOWER: lane_mask[i] = (i < DATA_W/2);
        PPP_EVEN:  lane_mask[i] = (((DATA_W-1-i)/8) % 2 == 0);
        PPP_ODD:   lane_mask[i] = (((DATA_W-1-i)/8) % 2 == 1);
        default:   lane_mask[i] = 1'b0;
      endcase
    end
  end

  // NOTE: the array is cleared by the async reset, so it must live in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      // NOTE: non-blocking so every reader in this edge sees the pre-write value.
      mem[wr_addr] <= merge(mem[wr_addr], wr_data, lane_mask);
    end
  end

  // A reserve issued alongside a write-back to the same register is a newer producer, so set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      if (wr_en) pending[wr_addr] <= 1'b0;
      if (rsv_en && rsv_addr != '0) pending[rsv_addr] <= 1'b1;
    end
  end

  assign hit_a = (BYPASS != 0) && wr_en && (wr_addr == rA_addr);
  assign hit_b = (BYPASS != 0) && wr_en && (wr_addr == rB_addr);

  assign a_comb = (rA_addr == '0) ? '0 :
                  hit_a ? merge(mem[rA_addr], wr_data, lane_mask) : mem[rA_addr];
  assign b_comb = (rB_addr == '0) ? '0 :
                  hit_b ? merge(mem[rB_addr], wr_data, lane_mask) : mem[rB_addr];

  assign rA_busy = reset && pending[rA_addr] && !hit_a;
  assign rB_busy = reset && pending[rB_addr] && !hit_b;

  generate
    if (READ_REG != 0) begin : g_read_reg
      logic [DATA_W-1:0] a_q, b_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rd_en) begin
          a_q <= a_comb;
          b_q <= b_comb;
        end
      end

      assign rA_data = a_q;
      assign rB_data = b_q;
    end else begin : g_read_comb
      logic unused_rd_en;
      assign unused_rd_en = rd_en;

      // Forwarding could otherwise leak wr_data onto the outputs while reset is held.
      assign rA_data = reset ? a_comb : '0;
      assign rB_data = reset ? b_comb : '0;
    end
  endgenerate

endmodule
